mult_share_arbiter: RTL

- Shares one 32x32->64 Karatsuba multiplier between two requesters. In the ElGamal datapath these are the key/exponentiation unit (port 0) and the encryption/ciphertext unit (port 1).
- Arbitrates operand issue round-robin and records the owner of every in-flight product in a tag FIFO.
- Routes each returning 64-bit product back to the requester that issued it, in issue order.
- Sits between the requesters and the multiplier's valid/ready stream interface.

---
 rtl/mult_share_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Two-requester front end for a shared 32x32->64 multiplier with in-order product return.
// Optional MULT_ARB_FIXED_PRIO_EN gives port 0 fixed priority instead of round-robin.
module mult_share_arbiter #(
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned TAG_AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       r0_a_tdata,
    input  logic [31:0]       r0_b_tdata,
    input  logic              r0_tvalid,
    output logic              r0_tready,
    input  logic [31:0]       r1_a_tdata,
    input  logic [31:0]       r1_b_tdata,
    input  logic              r1_tvalid,
    output logic              r1_tready,
    output logic [63:0]       q0_tdata,
    output logic              q0_tvalid,
    input  logic              q0_tready,
    output logic [63:0]       q1_tdata,
    output logic              q1_tvalid,
    input  logic              q1_tready,
    output logic [31:0]       m_a_tdata,
    output logic [31:0]       m_b_tdata,
    output logic              m_a_tvalid,
    output logic              m_b_tvalid,
    input  logic              m_a_tready,
    input  logic              m_b_tready,
    input  logic [63:0]       m_out_tdata,
    input  logic              m_out_tvalid,
    output logic              m_out_tready,
    output logic [TAG_AW:0]   inflight,
    output logic              err_orphan
);

    localparam logic [TAG_AW:0] DepthCnt = (TAG_AW + 1)'(TAG_DEPTH);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic [TAG_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TAG_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TAG_AW:0]     count_q, count_d;
    logic                tag_q [TAG_DEPTH];

    logic empty, full, head, head_ready, pop, push, req_valid, m_valid, pick;

    // Return path: head tag steers the product; empty FIFO swallows orphans.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DepthCnt);
        head         = tag_q[rd_ptr_q];
        head_ready   = head ? q1_tready : q0_tready;
        m_out_tready = empty ? m_out_tvalid : head_ready;
        pop          = m_out_tvalid & ~empty & head_ready;
        q0_tdata     = m_out_tdata;
        q1_tdata     = m_out_tdata;
        q0_tvalid    = m_out_tvalid & ~empty & ~head;
        q1_tvalid    = m_out_tvalid & ~empty & head;
    end

    // Issue path: a pop in the same cycle frees a slot for a push.
    always_comb begin
        req_valid  = grant_q ? r1_tvalid : r0_tvalid;
        m_valid    = (state_q == StHold) & req_valid & (~full | pop);
        m_a_tvalid = m_valid;
        m_b_tvalid = m_valid;
        push       = m_valid & m_a_tready & m_b_tready;
        r0_tready  = push & ~grant_q;
        r1_tready  = push & grant_q;
        m_a_tdata  = grant_q ? r1_a_tdata : r0_a_tdata;
        m_b_tdata  = grant_q ? r1_b_tdata : r0_b_tdata;
        inflight   = count_q;
        err_orphan = err_q;
    end

    always_comb begin
`ifdef MULT_ARB_FIXED_PRIO_EN
        pick = ~r0_tvalid;
`else
        pick = (r0_tvalid & r1_tvalid) ? ~last_q : r1_tvalid;
`endif
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        err_d    = err_q | (m_out_tvalid & empty);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (r0_tvalid | r1_tvalid) begin
                    grant_d = pick;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (push) begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_q[i] <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) tag_q[wr_ptr_q] <= grant_q;
        end
    end

endmodule
